// File: rtl/pulse_train_chk.sv
// rtl/pulse_train_chk.sv - checks a serial pulse burst for pulse count, high width and gap width
module pulse_train_chk #(
  parameter int PULSE_NUM = 3,
  parameter int HIGH_W    = 2,
  parameter int GAP_W     = 1,
  parameter int CNT_W     = 4,
  parameter int FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  output logic              busy,
  output logic [CNT_W-1:0]  pulse_cnt,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic [FCNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, HIGH, GAP, WAIT_LOW} state_t;

  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HIGH_C  = CNT_W'(HIGH_W);
  localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_W);
  localparam logic [CNT_W-1:0] PULSE_C = CNT_W'(PULSE_NUM);

  localparam logic [1:0] ERR_LONG  = 2'd1;
  localparam logic [1:0] ERR_SHORT = 2'd2;
  localparam logic [1:0] ERR_GAP   = 2'd3;

  state_t           state;
  logic [CNT_W-1:0] width_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] pulse_nxt;

  assign pulse_nxt = pulse_cnt + ONE_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      width_cnt <= '0;
      gap_cnt   <= '0;
      pulse_cnt <= '0;
      busy      <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      frame_cnt <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (din) begin
            state     <= HIGH;
            busy      <= 1'b1;
            width_cnt <= ONE_C;
            pulse_cnt <= '0;
            err_code  <= 2'd0;
          end
        end
        HIGH: begin
          if (din) begin
            // a pulse still high after HIGH_W samples must be drained before re-arming
            if (width_cnt >= HIGH_C) begin
              state     <= WAIT_LOW;
              frame_err <= 1'b1;
              err_code  <= ERR_LONG;
            end else begin
              width_cnt <= width_cnt + ONE_C;
            end
          end else if (width_cnt < HIGH_C) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            err_code  <= ERR_SHORT;
          end else begin
            pulse_cnt <= pulse_nxt;
            if (pulse_nxt == PULSE_C) begin
              state    <= IDLE;
              busy     <= 1'b0;
              frame_ok <= 1'b1;
              if (frame_cnt != '1) frame_cnt <= frame_cnt + FCNT_W'(1);
            end else begin
              state   <= GAP;
              gap_cnt <= ONE_C;
            end
          end
        end
        GAP: begin
          if (!din) begin
            if (gap_cnt >= GAP_C) begin
              state     <= IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
              err_code  <= ERR_GAP;
            end else begin
              gap_cnt <= gap_cnt + ONE_C;
            end
          end else if (gap_cnt < GAP_C) begin
            state     <= WAIT_LOW;
            frame_err <= 1'b1;
            err_code  <= ERR_GAP;
          end else begin
            state     <= HIGH;
            width_cnt <= ONE_C;
          end
        end
        WAIT_LOW: begin
          if (!din) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
